// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO register control.
//
// One MDU operation is accepted per start pulse. Its full result is computed at
// the accept edge and held in pending registers. busy stays high for a fixed
// latency, and then the result is committed to hi/lo. mthi/mtlo write
// immediately and do not raise busy. While an operation is in flight, stall
// asks the pipeline to hold any MDU-using instruction.
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst_n   in   1   asynchronous reset, active low
//   start   in   1   E-stage issues an MDU op this cycle
//   md_op   in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   flush   in   1   E-stage instruction cancelled; blocks the accept
//   md_use  in   1   E-stage instruction touches the MDU
//   data_a  in   32  rs operand
//   data_b  in   32  rt operand
//   busy    out  1   operation in flight
//   stall   out  1   combinational stall request
//   hi      out  32  committed HI
//   lo      out  32  committed LO
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        flush,
  input  logic        md_use,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic              accept;
  logic              op_long;
  logic [63:0]       prod_s, prod_u;
  logic [31:0]       a_mag, b_mag, b_safe, b_mag_safe;
  logic [31:0]       q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

  assign op_long = (md_op == OpMult) || (md_op == OpMultu) ||
                   (md_op == OpDiv)  || (md_op == OpDivu);
  assign accept  = start & ~flush & (state_q == StIdle);
  assign busy    = (state_q == StBusy);
  assign stall   = md_use & (busy | (start & ~flush & op_long));
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Arithmetic datapath, evaluated from the operands present at the accept edge.
  always_comb begin
    prod_s = {{32{data_a[31]}}, data_a} * {{32{data_b[31]}}, data_b};
    prod_u = {32'd0, data_a} * {32'd0, data_b};

    // Signed division through magnitudes: 0x80000000 / -1 gives 0x80000000 rem 0
    // without relying on signed-overflow behaviour of the operator.
    a_mag      = data_a[31] ? (32'd0 - data_a) : data_a;
    b_mag      = data_b[31] ? (32'd0 - data_b) : data_b;
    // Divide-by-zero results are discarded; a safe divisor keeps the datapath X-free.
    b_safe     = (data_b == 32'd0) ? 32'd1 : data_b;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    quot_s     = (data_a[31] ^ data_b[31]) ? (32'd0 - q_mag) : q_mag;
    rem_s      = data_a[31] ? (32'd0 - r_mag) : r_mag;
    quot_u     = data_a / b_safe;
    rem_u      = data_a % b_safe;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (md_op)
            OpMult: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              count_d   = CntW'(MULT_CYCLES - 1);
              state_d   = StBusy;
            end
            OpMultu: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              count_d   = CntW'(MULT_CYCLES - 1);
              state_d   = StBusy;
            end
            OpDiv: begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_wr_d = (data_b != 32'd0);
              count_d   = CntW'(DIV_CYCLES - 1);
              state_d   = StBusy;
            end
            OpDivu: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_wr_d = (data_b != 32'd0);
              count_d   = CntW'(DIV_CYCLES - 1);
              state_d   = StBusy;
            end
            OpMthi:  hi_d = data_a;
            OpMtlo:  lo_d = data_a;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (count_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = StIdle;
        end else begin
          count_d = count_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl. Inputs change on the falling edge and outputs
// are sampled shortly after it; every task is entered and left at a falling edge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic        flush;
  logic        md_use;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc;

  mdu_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .flush (flush),
    .md_use(md_use),
    .data_a(data_a),
    .data_b(data_b),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an op for one cycle with md_use set; stall must follow the op class.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    data_a = a;
    data_b = b;
    md_use = 1'b1;
    #1 check("stall_at_issue", 32'(stall), (op >= 3'd1 && op <= 3'd4) ? 32'd1 : 32'd0);
    @(negedge clk);
    start  = 1'b0;
    md_op  = 3'd0;
    md_use = 1'b0;
    #1;
  endtask

  // Count falling edges with busy high; bounded so a stuck busy still terminates.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd0;
    flush  = 1'b0;
    md_use = 1'b0;
    data_a = '0;
    data_b = '0;

    @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-operation clears hi and busy immediately.
    issue(3'd5, 32'h0000_0055, 32'd0);
    check("mthi_hi", hi, 32'h0000_0055);
    check("mthi_busy", 32'(busy), 32'd0);
    @(negedge clk);
    issue(3'd1, 32'd3, 32'd4);
    check("mult34_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_after_hi", hi, 32'd0);
    check("rstmid_after_busy", 32'(busy), 32'd0);

    // mult: -1 * 2.
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    check("mult_hold_lo", lo, 32'd0);
    wait_idle(n_cyc);
    check("mult_cycles", 32'(n_cyc), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    // multu: same operands.
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n_cyc);
    check("multu_cycles", 32'(n_cyc), 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // div: -7 / 2.
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n_cyc);
    check("div_cycles", 32'(n_cyc), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero: full latency, hi/lo untouched.
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n_cyc);
    check("divu0_cycles", 32'(n_cyc), 32'd10);
    check("divu0_lo", lo, 32'hFFFF_FFFD);
    check("divu0_hi", hi, 32'hFFFF_FFFF);

    // Ops during busy: mult 3*5 in flight, a second mult is stalled and ignored.
    issue(3'd1, 32'd3, 32'd5);
    start  = 1'b1;
    md_op  = 3'd1;
    data_a = 32'd100;
    data_b = 32'd100;
    md_use = 1'b1;
    #1 check("busy_start_stall", 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    #1;
    check("mfhi_stall", 32'(stall), 32'd1);
    check("mfhi_old_hi", hi, 32'hFFFF_FFFF);
    wait_idle(n_cyc);
    check("mfhi_stall_release", 32'(stall), 32'd0);
    md_use = 1'b0;
    check("ignored_lo", lo, 32'd15);
    check("ignored_hi", hi, 32'd0);
    @(negedge clk);
    #1;
    check("ignored_no_busy", 32'(busy), 32'd0);

    // Flush blocks the accept; an mtlo right after is taken.
    start  = 1'b1;
    flush  = 1'b1;
    md_op  = 3'd1;
    data_a = 32'd9;
    data_b = 32'd9;
    md_use = 1'b1;
    #1 check("flush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_lo", lo, 32'd15);
    issue(3'd6, 32'h0000_1234, 32'd0);
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_busy", 32'(busy), 32'd0);

    // Back-to-back: div issued in the cycle right after the mult commit.
    @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    wait_idle(n_cyc);
    check("b2b_mult_cycles", 32'(n_cyc), 32'd5);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    check("b2b_mult_lo", lo, 32'd42);
    issue(3'd3, 32'd100, 32'd7);
    check("b2b_div_busy", 32'(busy), 32'd1);
    wait_idle(n_cyc);
    check("b2b_div_cycles", 32'(n_cyc), 32'd10);
    check("b2b_div_lo", lo, 32'd14);
    check("b2b_div_hi", hi, 32'd2);

    // Signed overflow divide and a negative product.
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n_cyc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n_cyc);
    check("negmul_hi", hi, 32'hFFFF_FFFF);
    check("negmul_lo", lo, 32'hFFFF_FFF1);

    // md_op 7 with start: no effect.
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    check("op7_busy", 32'(busy), 32'd0);
    check("op7_lo", lo, 32'hFFFF_FFF1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
